// File: rtl/nvdla_bdma_rsp_pkg.sv
// Shared definitions for the BDMA read responder: bus widths, field offsets
// inside the request/response payloads, the FSM state type and the
// address-derived atom data pattern.
package nvdla_bdma_rsp_pkg;

    localparam int REQ_PD_W   = 79;
    localparam int RSP_PD_W   = 514;
    localparam int ADDR_W     = 64;
    localparam int SIZE_W     = 15;
    localparam int ATOM_BYTES = 32;
    localparam int ATOM_W     = 256;

    // Request payload: {size, address}
    localparam int REQ_ADDR_LSB  = 0;
    localparam int REQ_SIZE_LSB  = 64;

    // Response payload: {mask, atom1, atom0}
    localparam int RSP_ATOM0_LSB = 0;
    localparam int RSP_ATOM1_LSB = 256;
    localparam int RSP_MASK_LSB  = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_e;

    // An atom carries its own byte address replicated across 256 bits.
    function automatic logic [ATOM_W-1:0] atom_data(input logic [ADDR_W-1:0] addr);
        return {4{addr}};
    endfunction

endpackage

// File: rtl/nvdla_bdma_mcif_rd_responder_if.sv
// BDMA read request / response / credit-return bundle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source keeps valid high and its pd stable until that edge;
// ready may change freely and never depends combinationally on valid.
// The credit pop is a plain strobe: one credit returned per cycle it is high.
interface nvdla_bdma_mcif_rd_responder_if;
    import nvdla_bdma_rsp_pkg::*;

    logic                bdma2mcif_rd_req_valid;
    logic                bdma2mcif_rd_req_ready;
    logic [REQ_PD_W-1:0] bdma2mcif_rd_req_pd;
    logic                mcif2bdma_rd_rsp_valid;
    logic                mcif2bdma_rd_rsp_ready;
    logic [RSP_PD_W-1:0] mcif2bdma_rd_rsp_pd;
    logic                bdma2mcif_rd_cdt_lat_fifo_pop;

    // Requester (BDMA) side
    modport master (
        output bdma2mcif_rd_req_valid,
        input  bdma2mcif_rd_req_ready,
        output bdma2mcif_rd_req_pd,
        input  mcif2bdma_rd_rsp_valid,
        output mcif2bdma_rd_rsp_ready,
        input  mcif2bdma_rd_rsp_pd,
        output bdma2mcif_rd_cdt_lat_fifo_pop
    );

    // Responder (memory) side
    modport slave (
        input  bdma2mcif_rd_req_valid,
        output bdma2mcif_rd_req_ready,
        input  bdma2mcif_rd_req_pd,
        output mcif2bdma_rd_rsp_valid,
        input  mcif2bdma_rd_rsp_ready,
        output mcif2bdma_rd_rsp_pd,
        input  bdma2mcif_rd_cdt_lat_fifo_pop
    );

endinterface

// File: rtl/nvdla_bdma_rsp_req_fifo.sv
// Flop-based request queue. Both status flags are registered so that the
// request ready seen by the BDMA comes straight from a flop.
module nvdla_bdma_rsp_req_fifo
    import nvdla_bdma_rsp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push_i,
    input  logic [REQ_PD_W-1:0] push_pd_i,
    input  logic                pop_i,
    output logic [REQ_PD_W-1:0] pop_pd_o,
    output logic                not_full_o,
    output logic                not_empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [REQ_PD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                not_full_q, not_empty_q;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and registered flags; ready stays low during reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_full_q  <= 1'b0;
            not_empty_q <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            not_full_q  <= (count_d != CNT_W'(DEPTH));
            not_empty_q <= (count_d != '0);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_pd_i;
    end

    assign pop_pd_o    = mem_q[rd_ptr_q];
    assign not_full_o  = not_full_q;
    assign not_empty_o = not_empty_q;

endmodule

// File: rtl/nvdla_bdma_mcif_rd_responder.sv
// Memory stand-in for the BDMA read channel: queues read requests, waits a
// fixed latency, then streams two-atom response beats whose data is derived
// from the atom address. Beat issue is limited by latency-FIFO credits.
// Optional build macro NVDLA_BDMA_RSP_BACKPRESSURE_EN adds LFSR-driven
// throttling of request ready and new response beats.
module nvdla_bdma_mcif_rd_responder
    import nvdla_bdma_rsp_pkg::*;
#(
    parameter int REQ_DEPTH      = 4,
    parameter int LATENCY        = 8,
    parameter int LAT_FIFO_DEPTH = 16
) (
    input  logic                                 nvdla_core_clk,
    input  logic                                 nvdla_core_rstn,
    nvdla_bdma_mcif_rd_responder_if.slave        bus,
    output logic                                 rsp_credit_ovf,
    output logic                                 rsp_idle,
    output state_e                               dbg_state,
    output logic [$clog2(LAT_FIFO_DEPTH+1)-1:0]  dbg_credits
);

    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int CDT_W = $clog2(LAT_FIFO_DEPTH + 1);
    localparam logic [CDT_W-1:0]  CDT_FULL = CDT_W'(LAT_FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_ATOM = ADDR_W'(ATOM_BYTES);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [SIZE_W:0]     atoms_left_q, atoms_left_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [CDT_W-1:0]    credits_q, credits_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RSP_PD_W-1:0] rsp_pd_q, rsp_pd_d;
    logic                ovf_q, ovf_d;

    logic [REQ_PD_W-1:0] fifo_pd;
    logic                fifo_not_full, fifo_not_empty;
    logic                fifo_push, fifo_pop;
    logic                req_gate, issue_gate;
    logic                accept, cdt_pop, load, two_atoms, stream_win;
    logic [CDT_W:0]      cdt_sum;

`ifdef NVDLA_BDMA_RSP_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign req_gate   = (lfsr_q[1:0] != 2'b00);
    assign issue_gate = (lfsr_q[3:2] != 2'b00);
`else
    assign req_gate   = 1'b1;
    assign issue_gate = 1'b1;
`endif

    assign bus.bdma2mcif_rd_req_ready = fifo_not_full & req_gate;
    assign fifo_push = bus.bdma2mcif_rd_req_valid & bus.bdma2mcif_rd_req_ready;
    assign accept    = rsp_valid_q & bus.mcif2bdma_rd_rsp_ready;
    assign cdt_pop   = bus.bdma2mcif_rd_cdt_lat_fifo_pop;

    nvdla_bdma_rsp_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk         (nvdla_core_clk),
        .rstn        (nvdla_core_rstn),
        .push_i      (fifo_push),
        .push_pd_i   (bus.bdma2mcif_rd_req_pd),
        .pop_i       (fifo_pop),
        .pop_pd_o    (fifo_pd),
        .not_full_o  (fifo_not_full),
        .not_empty_o (fifo_not_empty)
    );

    // Next-state, beat construction and credit accounting
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        atoms_left_d = atoms_left_q;
        lat_cnt_d    = lat_cnt_q;
        credits_d    = credits_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_pd_d     = rsp_pd_q;
        ovf_d        = ovf_q;
        fifo_pop     = 1'b0;

        // Credits that will remain once this cycle's accept/pop settle; a new
        // beat may only be presented if one is left for it.
        cdt_sum    = {1'b0, credits_q} + {{CDT_W{1'b0}}, cdt_pop} - {{CDT_W{1'b0}}, accept};
        // The last WAIT cycle already counts as streaming so the first beat
        // appears exactly LATENCY cycles after the dequeue.
        stream_win = (state_q == STREAM) || ((state_q == WAIT) && (lat_cnt_q == '0));
        two_atoms  = (atoms_left_q != 1);
        load       = stream_win && (atoms_left_q != '0) && (!rsp_valid_q || accept) &&
                     (cdt_sum != '0) && issue_gate;

        case (state_q)
            IDLE: begin
                if (fifo_not_empty) fifo_pop = 1'b1;
            end
            WAIT: begin
                if (lat_cnt_q == '0) state_d = STREAM;
                else                 lat_cnt_d = lat_cnt_q - 1'b1;
            end
            STREAM: begin
                // Every atom has been loaded; finishing means the last beat is taken
                if (accept && (atoms_left_q == '0)) begin
                    state_d = IDLE;
                    if (fifo_not_empty) fifo_pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifo_pop) begin
            cur_addr_d   = fifo_pd[REQ_ADDR_LSB +: ADDR_W];
            atoms_left_d = {1'b0, fifo_pd[REQ_SIZE_LSB +: SIZE_W]} + 1'b1;
            lat_cnt_d    = LAT_W'(LATENCY - 1);
            state_d      = WAIT;
        end

        if (load) begin
            rsp_pd_d = '0;
            rsp_pd_d[RSP_ATOM0_LSB +: ATOM_W] = atom_data(cur_addr_q);
            if (two_atoms) begin
                rsp_pd_d[RSP_ATOM1_LSB +: ATOM_W] = atom_data(cur_addr_q + ONE_ATOM);
                rsp_pd_d[RSP_MASK_LSB +: 2]       = 2'b11;
                cur_addr_d   = cur_addr_q + ONE_ATOM + ONE_ATOM;
                atoms_left_d = atoms_left_q - 2'd2;
            end else begin
                rsp_pd_d[RSP_MASK_LSB +: 2]       = 2'b01;
                cur_addr_d   = cur_addr_q + ONE_ATOM;
                atoms_left_d = atoms_left_q - 1'b1;
            end
            rsp_valid_d = 1'b1;
        end else if (accept) begin
            rsp_valid_d = 1'b0;
        end

        if (cdt_pop && !accept) begin
            if (credits_q != CDT_FULL) credits_d = credits_q + 1'b1;
        end else if (accept && !cdt_pop) begin
            credits_d = credits_q - 1'b1;
        end
        if (cdt_pop && (credits_q == CDT_FULL)) ovf_d = 1'b1;
    end

    // State register; reset drops any outstanding burst
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            atoms_left_q <= '0;
            lat_cnt_q    <= '0;
            credits_q    <= CDT_FULL;
            rsp_valid_q  <= 1'b0;
            rsp_pd_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            atoms_left_q <= atoms_left_d;
            lat_cnt_q    <= lat_cnt_d;
            credits_q    <= credits_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_pd_q     <= rsp_pd_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.mcif2bdma_rd_rsp_valid = rsp_valid_q;
    assign bus.mcif2bdma_rd_rsp_pd    = rsp_pd_q;
    assign rsp_credit_ovf             = ovf_q;
    assign rsp_idle                   = !fifo_not_empty && (state_q == IDLE) && !rsp_valid_q;
    assign dbg_state                  = state_q;
    assign dbg_credits                = credits_q;

endmodule
